// File: rtl/nonce_result_buffer.sv
// Gathers golden nonces from the hashing cores through one-entry holding registers,
// arbitrates them round-robin into a show-ahead FIFO, and backpressures cores when full.
module nonce_result_buffer #(
  parameter int NUM_CORES = 10,
  parameter int DEPTH     = 16,
  parameter int NONCE_W   = 32,
  parameter int CORE_W    = $clog2(NUM_CORES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_CORES-1:0]         hit_valid,
  input  logic [NUM_CORES*NONCE_W-1:0] hit_nonce,
  output logic [NUM_CORES-1:0]         hit_ready,
  output logic                         rd_valid,
  output logic [NONCE_W-1:0]           rd_nonce,
  output logic [CORE_W-1:0]            rd_core,
  input  logic                         rd_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fill_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [NUM_CORES-1:0] held_q, held_d;
  logic [NONCE_W-1:0]   held_nonce_q [NUM_CORES];
  logic [CORE_W-1:0]    rr_q, rr_d;
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NONCE_W-1:0]   mem_nonce_q [DEPTH];
  logic [CORE_W-1:0]    mem_core_q  [DEPTH];

  logic [NUM_CORES-1:0] cap_s;
  logic                 full_s, empty_s, gnt_vld_s, push_s, pop_s;
  logic [CORE_W-1:0]    gnt_idx_s;
  logic [CORE_W:0]      scan_idx_s;

  assign full_s  = (count_q == CNT_W'(DEPTH));
  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign cap_s   = hit_valid & ~held_q & {NUM_CORES{~flush}};
  assign push_s  = gnt_vld_s & ~flush;
  assign pop_s   = ~empty_s & rd_ready & ~flush;

  // Round-robin search for the first held core starting at rr, gated by FIFO room.
  always_comb begin
    gnt_vld_s  = 1'b0;
    gnt_idx_s  = {CORE_W{1'b0}};
    scan_idx_s = {(CORE_W+1){1'b0}};
    for (int k = 0; k < NUM_CORES; k++) begin
      scan_idx_s = {1'b0, rr_q} + (CORE_W+1)'(k);
      if (scan_idx_s >= (CORE_W+1)'(NUM_CORES)) begin
        scan_idx_s = scan_idx_s - (CORE_W+1)'(NUM_CORES);
      end else begin
        scan_idx_s = scan_idx_s;
      end
      if (!gnt_vld_s && !full_s && held_q[scan_idx_s[CORE_W-1:0]]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = scan_idx_s[CORE_W-1:0];
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
  end

  // Next-state for holding flags, arbiter pointer and FIFO pointers/occupancy.
  always_comb begin
    held_d  = held_q;
    rr_d    = rr_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      held_d  = {NUM_CORES{1'b0}};
      rr_d    = {CORE_W{1'b0}};
      wptr_d  = {AW{1'b0}};
      rptr_d  = {AW{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      held_d = held_q | cap_s;
      if (push_s) begin
        held_d[gnt_idx_s] = 1'b0;
        rr_d   = (gnt_idx_s == CORE_W'(NUM_CORES-1)) ? {CORE_W{1'b0}} : gnt_idx_s + CORE_W'(1);
        wptr_d = wptr_q + AW'(1);
      end else begin
        rr_d   = rr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + AW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers; reset matches the flush state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q  <= {NUM_CORES{1'b0}};
      rr_q    <= {CORE_W{1'b0}};
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      held_q  <= held_d;
      rr_q    <= rr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Nonce payload storage; only ever observed while its valid flag is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (cap_s[i]) begin
        held_nonce_q[i] <= hit_nonce[i*NONCE_W +: NONCE_W];
      end
    end
    if (push_s) begin
      mem_nonce_q[wptr_q] <= held_nonce_q[gnt_idx_s];
      mem_core_q[wptr_q]  <= gnt_idx_s;
    end
  end

  assign hit_ready  = ~held_q;
  assign rd_valid   = ~empty_s;
  assign rd_nonce   = empty_s ? {NONCE_W{1'b0}} : mem_nonce_q[rptr_q];
  assign rd_core    = empty_s ? {CORE_W{1'b0}}  : mem_core_q[rptr_q];
  assign fill_count = count_q;

endmodule

// File: tb/tb_nonce_result_buffer.sv
// Scoreboard bench for nonce_result_buffer: expected {core, nonce} pairs are queued as
// hits are driven and compared against the FIFO head whenever the reader pops.
module tb_nonce_result_buffer;

  localparam int NC = 10;
  localparam int NW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [NC-1:0]    hit_valid;
  logic [NC*NW-1:0] hit_nonce;
  logic [NC-1:0]    hit_ready;
  logic             rd_valid;
  logic [NW-1:0]    rd_nonce;
  logic [3:0]       rd_core;
  logic             rd_ready;
  logic [4:0]       fill_count;

  typedef struct {
    logic [3:0]  core;
    logic [31:0] nonce;
  } exp_t;

  exp_t sb_q [$];
  int   total = 0;
  int   bad   = 0;

  nonce_result_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .hit_valid(hit_valid), .hit_nonce(hit_nonce), .hit_ready(hit_ready),
    .rd_valid(rd_valid), .rd_nonce(rd_nonce), .rd_core(rd_core),
    .rd_ready(rd_ready), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pop the scoreboard whenever the reader accepts the head.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pop", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rd_core", 64'(rd_core), 64'(e.core));
        check("rd_nonce", 64'(rd_nonce), 64'(e.nonce));
      end
    end
  end

  // Entered just after a rising edge; presents one cycle of hits, nonce = base + core.
  task automatic drive_hits(input logic [NC-1:0] mask, input logic [31:0] base, input bit push_sb);
    for (int i = 0; i < NC; i++) begin
      hit_nonce[i*NW +: NW] = base + 32'(i);
      if (push_sb && mask[i]) sb_q.push_back('{core: 4'(i), nonce: base + 32'(i)});
    end
    hit_valid = mask;
    @(posedge clk); #1;
    hit_valid = '0;
  endtask

  task automatic wait_empty(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0 && fill_count == 5'd0) done = 1'b1;
    end
    check("drain_done", 64'(done), 64'd1);
  endtask

  // Single hit with empty FIFO: rd_valid low one cycle after capture, high the next.
  task automatic single_hit(input int core, input logic [31:0] nonce);
    rd_ready = 1'b1;
    hit_nonce[core*NW +: NW] = nonce;
    hit_valid = '0;
    hit_valid[core] = 1'b1;
    sb_q.push_back('{core: 4'(core), nonce: nonce});
    @(posedge clk); #1;
    hit_valid = '0;
    @(negedge clk);
    check("lat_cycle1_valid", 64'(rd_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 64'(rd_valid), 64'd1);
    wait_empty(10);
    check("single_fill_zero", 64'(fill_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; hit_valid = '0; hit_nonce = '0; rd_ready = 1'b0;
    #1;
    check("rst_hit_ready", 64'(hit_ready), 64'h3FF);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_nonce", 64'(rd_nonce), 64'd0);
    check("rst_fill", 64'(fill_count), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention: all cores at once, twice; order 0..9 both times.
    rd_ready = 1'b1;
    drive_hits(10'h3FF, 32'h0, 1'b1);
    wait_empty(40);
    drive_hits(10'h3FF, 32'h0, 1'b1);
    wait_empty(40);

    // Fairness: granting core 4 leaves rr=5, so 7 beats 2.
    drive_hits(10'h010, 32'h4400, 1'b1);
    wait_empty(10);
    sb_q.push_back('{core: 4'd7, nonce: 32'h7707});
    sb_q.push_back('{core: 4'd2, nonce: 32'h7702});
    drive_hits(10'h084, 32'h7700, 1'b0);
    wait_empty(10);

    single_hit(3, 32'hDEADBEEF);

    // Backpressure: 20 hits into a 16-entry FIFO.
    rd_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drive_hits(10'h3FF, 32'h100, 1'b1);
    repeat (12) @(posedge clk); #1;
    check("bp_fill10", 64'(fill_count), 64'd10);
    drive_hits(10'h3FF, 32'h200, 1'b1);
    repeat (8) @(posedge clk); #1;
    check("bp_fill_sat", 64'(fill_count), 64'd16);
    check("bp_hit_ready", 64'(hit_ready), 64'h03F);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_pop_nopush_fill", 64'(fill_count), 64'd15);
    check("bp_pop_nopush_ready", 64'(hit_ready), 64'h03F);
    @(posedge clk); #1;
    check("bp_push_pop_fill", 64'(fill_count), 64'd15);
    check("bp_push_pop_ready", 64'(hit_ready), 64'h07F);
    wait_empty(60);

    // Flush with 5 buffered and 2 held while core 1 offers a hit.
    rd_ready = 1'b0;
    drive_hits(10'h07F, 32'h300, 1'b1);
    repeat (5) @(posedge clk); #1;
    check("fl_pre_fill", 64'(fill_count), 64'd5);
    check("fl_pre_ready", 64'(hit_ready), 64'h39F);
    flush = 1'b1;
    hit_nonce[1*NW +: NW] = 32'hF1F1F1F1;
    hit_valid = 10'h002;
    sb_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_fill", 64'(fill_count), 64'd0);
    check("fl_rd_valid", 64'(rd_valid), 64'd0);
    check("fl_hit_ready", 64'(hit_ready), 64'h3FF);
    sb_q.push_back('{core: 4'd1, nonce: 32'hF1F1F1F1});
    @(posedge clk); #1;
    hit_valid = '0;
    check("fl_recapture", 64'(hit_ready), 64'h3FD);
    rd_ready = 1'b1;
    wait_empty(10);

    // Asynchronous reset mid-cycle with 8 buffered.
    rd_ready = 1'b0;
    drive_hits(10'h0FF, 32'h500, 1'b1);
    repeat (10) @(posedge clk); #1;
    check("ar_pre_fill", 64'(fill_count), 64'd8);
    @(posedge clk); #3;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("ar_fill", 64'(fill_count), 64'd0);
    check("ar_rd_valid", 64'(rd_valid), 64'd0);
    check("ar_rd_nonce", 64'(rd_nonce), 64'd0);
    check("ar_rd_core", 64'(rd_core), 64'd0);
    check("ar_hit_ready", 64'(hit_ready), 64'h3FF);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    single_hit(5, 32'hCAFEF00D);

    check("sb_empty_end", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nonce_result_buffer.md
# nonce_result_buffer

Collects golden nonces reported by the `NUM_CORES` hashing cores inside `bcminer`, arbitrates them round-robin into a single FIFO, and presents them one at a time to the nonce-buffer reader. It sits directly downstream of the cores. It is the storage behind the `nonceBufferIfc` writer path. No result is ever dropped: full conditions backpressure the cores. A per-block flush discards stale results when a new block header is loaded.

## Interface
- `NUM_CORES`, 10, number of hashing cores feeding the buffer (≥2).
- `DEPTH`, 16, FIFO entries (power of two, ≥2).
- `NONCE_W`, 32, nonce width.
- `CORE_W`, derived `$clog2(NUM_CORES)`, core-index width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all buffered results (new block loaded).
- `hit_valid`  in  NUM_CORES  per-core: nonce found this cycle.
- `hit_nonce`  in  NUM_CORES*NONCE_W  per-core nonce; core i at bits [i*NONCE_W +: NONCE_W].
- `hit_ready`  out  NUM_CORES  per-core: holding register free.
- `rd_valid`  out  1  FIFO head valid.
- `rd_nonce`  out  NONCE_W  head nonce.
- `rd_core`  out  CORE_W  index of the core that found the head nonce.
- `rd_ready`  in  1  reader accepts the head this cycle.
- `fill_count`  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Each core i has a one-entry holding register (`held[i]`, nonce).
  - `hit_ready[i] = ~held[i]`, combinational from the register state.
  - A hit with `hit_valid[i] & hit_ready[i]` sets `held[i]` and captures the nonce at the edge.
  - A hit with `hit_valid[i]` while `held[i]` is set is not accepted. The core must hold `valid` and the nonce until ready.
- Arbiter, round-robin pointer `rr`, range 0..NUM_CORES-1, reset 0.
  - Each cycle it grants the first core j with `held[j]`, searching j = rr, rr+1, … modulo NUM_CORES.
  - It grants only when the FIFO is not full (`fill_count < DEPTH`).
  - On a grant: push {j, nonce_j} into the FIFO, clear `held[j]`, set `rr = (j+1) mod NUM_CORES`.
  - With no grant, `rr` is unchanged. At most one grant per cycle.
- FIFO is show-ahead: `rd_nonce`/`rd_core` reflect the head whenever `rd_valid = (fill_count != 0)`.
  - Pop on `rd_valid & rd_ready`. `rd_ready` while empty is ignored.
  - Push and pop in the same cycle: `fill_count` is unchanged. A full FIFO does not push, even if a pop occurs.
  - Read/write pointers wrap modulo DEPTH.
- `fill_count` = pushes minus pops. It never exceeds DEPTH and never goes negative.
- `flush` has highest priority. At the edge it:
  - clears all `held`, the FIFO (`fill_count = 0`) and `rr = 0`;
  - performs no push, pop, or hit capture that cycle. Hits offered during a flush cycle are discarded.
- Reset (`rst_n` low, asynchronous) produces the same state as flush.
  - Outputs during and after reset: `hit_ready` all 1, `rd_valid` 0, `rd_nonce` 0, `rd_core` 0, `fill_count` 0.
  - Empty-FIFO data outputs read 0. Storage RAM need not be cleared, but `rd_nonce`/`rd_core` are masked to 0 when empty.

## Timing
- Hit accepted at edge of cycle 0. Grant and push at edge of cycle 1. `rd_valid` is high during cycle 2 (latency 2, FIFO empty, no contention).
- A single core can deliver at most one hit every 2 cycles (ready drops for 1 cycle after capture when granted immediately).
- Throughput: 1 result/cycle into the FIFO while holding registers are pending and the FIFO has room.
- A full FIFO plus all holding registers full gives `hit_ready` all 0. The first pop re-enables a grant in the same cycle only if the FIFO was not full at cycle start. Otherwise the grant comes next cycle.
- Reset assertion mid-operation clears state immediately (asynchronous). Deassertion is synchronous to `clk`. The first capture is possible at the first edge after release.

## Test plan
- Single hit: core 3 presents `nonce=0xDEADBEEF` for 1 cycle with `rd_ready=1` -> `rd_valid` in cycle 2 with `rd_nonce=0xDEADBEEF`, `rd_core=3`; `fill_count` returns to 0 after the pop.
- Contention: all 10 cores hit in the same cycle with `nonce=i`, `rd_ready=1` -> FIFO outputs cores 0,1,…,9 in order on consecutive cycles. A second burst after that yields 0..9 again (`rr` wrapped to 0).
- Round-robin fairness: with `rr=5` (after granting core 4), cores 2 and 7 held -> 7 is granted first, then 2.
- Full/backpressure: `rd_ready=0`, 20 hits from cores 0..9 twice.
  - `fill_count` saturates at 16. The remaining holding registers stay held and their `hit_ready` are 0.
  - Raising `rd_ready` drains all 20 with none lost or duplicated.
  - At full, simultaneous pop and pending hold -> no push that cycle, push next cycle.
- Flush: 5 results buffered plus 2 held; assert `flush` for 1 cycle while core 1 presents a new hit.
  - Next cycle: `fill_count=0`, `rd_valid=0`, all `hit_ready=1`.
  - Core 1's hit is not captured; it is captured the following cycle if still presented.
- Reset mid-operation: drop `rst_n` asynchronously mid-cycle with 8 results buffered -> outputs go to reset values immediately. After release, normal single-hit latency of 2 is preserved.
